// File: rtl/csi2_raw10_depacker.sv
// ---------------------------------------------------------------------------
// csi2_raw10_depacker
//
// Parses the CSI-2 packet stream coming out of the D-PHY lane merger and
// unpacks RAW10 long-packet payload into groups of four 10-bit pixels.
// Frame-start / frame-end short packets produce one-cycle pulses, a per-frame
// count of completed RAW10 lines is kept, and malformed or truncated packets
// are flagged on pkt_err and dropped. The block never stalls its input.
//
// Ports
//   wfifo_wr_clk  in   clock
//   s_rst_n       in   asynchronous active-low reset
//   csi_data      in   [15:0] two bytes per beat, byte0 = [7:0] is first
//   csi_vld       in   beat qualifier (no backpressure)
//   csi_sop       in   first beat of a packet (qualified by csi_vld)
//   pixel_data    out  [39:0] {P0,P1,P2,P3}, P0 in [39:30]
//   pixel_vld     out  one-cycle strobe per complete 5-byte group
//   frame_start   out  one-cycle pulse on an FS short packet
//   frame_end     out  one-cycle pulse on an FE short packet
//   line_cnt      out  [LINE_W-1:0] RAW10 lines completed since last FS
//   pkt_err       out  one-cycle pulse on a protocol error
//   dbg_state     out  [1:0] current FSM state (0 IDLE,1 HDR,2 PAYLOAD,3 CRC)
//
// Handshake: a beat is transferred on every rising edge where csi_vld=1;
// there is no ready signal, so every valid beat is consumed in that cycle.
// Cycles with csi_vld=0 leave all state untouched.
// ---------------------------------------------------------------------------
module csi2_raw10_depacker #(
    parameter logic [5:0] DT_RAW10 = 6'h2B,
    parameter int         LINE_W   = 12
) (
    input  logic              wfifo_wr_clk,
    input  logic              s_rst_n,
    input  logic [15:0]       csi_data,
    input  logic              csi_vld,
    input  logic              csi_sop,
    output logic [39:0]       pixel_data,
    output logic              pixel_vld,
    output logic              frame_start,
    output logic              frame_end,
    output logic [LINE_W-1:0] line_cnt,
    output logic              pkt_err,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HDR     = 2'd1,
        ST_PAYLOAD = 2'd2,
        ST_CRC     = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [5:0]          di_q, di_d;
    logic [7:0]          wc_lo_q, wc_lo_d;
    logic                keep_q, keep_d;
    logic [15:0]         remaining_q, remaining_d;
    logic [2:0]          grp_cnt_q, grp_cnt_d;
    logic [3:0][7:0]     gath_q, gath_d;
    logic [1:0]          crc_left_q, crc_left_d;
    logic [39:0]         pixel_data_q, pixel_data_d;
    logic                pixel_vld_q, pixel_vld_d;
    logic                frame_start_q, frame_start_d;
    logic                frame_end_q, frame_end_d;
    logic [LINE_W-1:0]   line_cnt_q, line_cnt_d;
    logic                pkt_err_q, pkt_err_d;

    logic [7:0]          byte0;
    logic [7:0]          byte1;
    logic [7:0]          cur_byte;
    logic [15:0]         wc;
    logic                take2;

    assign byte0 = csi_data[7:0];
    assign byte1 = csi_data[15:8];
    // Word count: low byte captured with the SOP beat, high byte in HDR beat.
    assign wc    = {byte0, wc_lo_q};

    always_comb begin
        state_d       = state_q;
        di_d          = di_q;
        wc_lo_d       = wc_lo_q;
        keep_d        = keep_q;
        remaining_d   = remaining_q;
        grp_cnt_d     = grp_cnt_q;
        gath_d        = gath_q;
        crc_left_d    = crc_left_q;
        pixel_data_d  = pixel_data_q;
        pixel_vld_d   = 1'b0;
        frame_start_d = 1'b0;
        frame_end_d   = 1'b0;
        line_cnt_d    = line_cnt_q;
        pkt_err_d     = 1'b0;
        cur_byte      = 8'h00;
        take2         = (remaining_q >= 16'd2);

        if (csi_vld) begin
            if (csi_sop) begin
                // A new packet start anywhere but IDLE aborts the current one;
                // any partially gathered group is thrown away.
                if (state_q != ST_IDLE) begin
                    pkt_err_d = 1'b1;
                end
                grp_cnt_d = 3'd0;
                di_d      = byte0[5:0];
                wc_lo_d   = byte1;
                state_d   = ST_HDR;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        // Stray beats without SOP are ignored.
                    end
                    ST_HDR: begin
                        if (di_q == 6'h00) begin
                            frame_start_d = 1'b1;
                            line_cnt_d    = '0;
                            state_d       = ST_IDLE;
                        end else if (di_q == 6'h01) begin
                            frame_end_d = 1'b1;
                            state_d     = ST_IDLE;
                        end else if (di_q < 6'h10) begin
                            state_d = ST_IDLE;
                        end else begin
                            keep_d      = (di_q == DT_RAW10) && (wc != 16'd0);
                            remaining_d = wc;
                            grp_cnt_d   = 3'd0;
                            if (wc == 16'd0) begin
                                crc_left_d = 2'd2;
                                state_d    = ST_CRC;
                            end else begin
                                state_d = ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        for (int i = 0; i < 2; i++) begin
                            if (i == 0 || take2) begin
                                cur_byte = (i == 0) ? byte0 : byte1;
                                if (keep_q) begin
                                    if (grp_cnt_d == 3'd4) begin
                                        // Fifth byte carries the 2 LSBs of each pixel.
                                        pixel_data_d = {gath_d[0], cur_byte[1:0],
                                                        gath_d[1], cur_byte[3:2],
                                                        gath_d[2], cur_byte[5:4],
                                                        gath_d[3], cur_byte[7:6]};
                                        pixel_vld_d  = 1'b1;
                                        grp_cnt_d    = 3'd0;
                                    end else begin
                                        gath_d[grp_cnt_d[1:0]] = cur_byte;
                                        grp_cnt_d = grp_cnt_d + 3'd1;
                                    end
                                end
                            end
                        end
                        remaining_d = remaining_q - (take2 ? 16'd2 : 16'd1);
                        if (remaining_d == 16'd0) begin
                            // If only byte0 was payload, byte1 was CRC byte 0.
                            crc_left_d = take2 ? 2'd2 : 2'd1;
                            state_d    = ST_CRC;
                            if (keep_q) begin
                                if (grp_cnt_d != 3'd0) begin
                                    pkt_err_d = 1'b1;
                                    grp_cnt_d = 3'd0;
                                end else if (line_cnt_q != {LINE_W{1'b1}}) begin
                                    line_cnt_d = line_cnt_q + LINE_W'(1);
                                end
                            end
                        end
                    end
                    ST_CRC: begin
                        // CRC is not checked; surplus bytes in the beat are dropped.
                        if (crc_left_q <= 2'd2) begin
                            crc_left_d = 2'd0;
                            state_d    = ST_IDLE;
                        end else begin
                            crc_left_d = crc_left_q - 2'd2;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge wfifo_wr_clk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q       <= ST_IDLE;
            di_q          <= '0;
            wc_lo_q       <= '0;
            keep_q        <= 1'b0;
            remaining_q   <= '0;
            grp_cnt_q     <= '0;
            gath_q        <= '0;
            crc_left_q    <= '0;
            pixel_data_q  <= '0;
            pixel_vld_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            line_cnt_q    <= '0;
            pkt_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            di_q          <= di_d;
            wc_lo_q       <= wc_lo_d;
            keep_q        <= keep_d;
            remaining_q   <= remaining_d;
            grp_cnt_q     <= grp_cnt_d;
            gath_q        <= gath_d;
            crc_left_q    <= crc_left_d;
            pixel_data_q  <= pixel_data_d;
            pixel_vld_q   <= pixel_vld_d;
            frame_start_q <= frame_start_d;
            frame_end_q   <= frame_end_d;
            line_cnt_q    <= line_cnt_d;
            pkt_err_q     <= pkt_err_d;
        end
    end

    assign pixel_data  = pixel_data_q;
    assign pixel_vld   = pixel_vld_q;
    assign frame_start = frame_start_q;
    assign frame_end   = frame_end_q;
    assign line_cnt    = line_cnt_q;
    assign pkt_err     = pkt_err_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_csi2_raw10_depacker.sv
// ---------------------------------------------------------------------------
// tb_csi2_raw10_depacker
//
// Directed bench for csi2_raw10_depacker: a table of packets with their
// expected pulse counts and line_cnt evolution, plus hand-written sequences
// for the literal RAW10 example, SOP abort and reset mid-packet.
// ---------------------------------------------------------------------------
module tb_csi2_raw10_depacker;

    localparam logic [5:0] DT_RAW10 = 6'h2B;
    localparam int         LINE_W   = 12;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              s_rst_n = 1'b0;
    logic [15:0]       csi_data = 16'h0000;
    logic              csi_vld = 1'b0;
    logic              csi_sop = 1'b0;
    logic [39:0]       pixel_data;
    logic              pixel_vld;
    logic              frame_start;
    logic              frame_end;
    logic [LINE_W-1:0] line_cnt;
    logic              pkt_err;
    logic [1:0]        dbg_state;

    always #5 clk = ~clk;

    csi2_raw10_depacker #(.DT_RAW10(DT_RAW10), .LINE_W(LINE_W)) dut (
        .wfifo_wr_clk (clk),
        .s_rst_n      (s_rst_n),
        .csi_data     (csi_data),
        .csi_vld      (csi_vld),
        .csi_sop      (csi_sop),
        .pixel_data   (pixel_data),
        .pixel_vld    (pixel_vld),
        .frame_start  (frame_start),
        .frame_end    (frame_end),
        .line_cnt     (line_cnt),
        .pkt_err      (pkt_err),
        .dbg_state    (dbg_state)
    );

    // ---------------- scoreboard / bookkeeping ----------------
    int chk_cnt  = 0;
    int pass_cnt = 0;
    logic [39:0] exp_q[$];
    int pix_cnt = 0, err_cnt = 0, fs_cnt = 0, fe_cnt = 0;
    int cyc = 0, last_pix_cyc = -100;
    int exp_line = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [39:0] make_group(input logic [7:0] b0, input logic [7:0] b1,
                                               input logic [7:0] b2, input logic [7:0] b3,
                                               input logic [7:0] b4);
        return {b0, b4[1:0], b1, b4[3:2], b2, b4[5:4], b3, b4[7:6]};
    endfunction

    always @(posedge clk) cyc++;

    // Output monitor: counts pulses and checks every pixel group in order.
    always @(negedge clk) begin
        if (s_rst_n) begin
            if (frame_start) fs_cnt++;
            if (frame_end)   fe_cnt++;
            if (pkt_err)     err_cnt++;
            if (pixel_vld) begin
                pix_cnt++;
                if (last_pix_cyc >= 0)
                    check("pix_spacing_ge2", 64'(cyc - last_pix_cyc >= 2), 64'd1);
                last_pix_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("pix_unexpected", 64'(pixel_data), 64'hDEAD_BEEF_00);
                end else begin
                    check("pix_data", 64'(pixel_data), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic beat(input logic [15:0] d, input logic sop);
        @(negedge clk);
        csi_data = d;
        csi_vld  = 1'b1;
        csi_sop  = sop;
    endtask

    task automatic idle();
        @(negedge clk);
        csi_data = 16'($urandom_range(0, 65535));
        csi_vld  = 1'b0;
        csi_sop  = 1'b0;
    endtask

    task automatic settle();
        repeat (3) idle();
    endtask

    task automatic maybe_gap(input bit gaps);
        if (gaps) repeat ($urandom_range(0, 2)) idle();
    endtask

    // Sends one packet; payload byte k is seed+k, CRC bytes are 0xCC.
    task automatic send_pkt(input logic [5:0] dt, input logic [15:0] wc,
                            input logic [7:0] seed, input bit gaps);
        logic [7:0] stream[$];
        logic [7:0] lo, hi;
        beat({(dt < 6'h10) ? 8'h00 : wc[7:0], 2'b00, dt}, 1'b1);
        maybe_gap(gaps);
        beat({8'hEC, (dt < 6'h10) ? 8'h00 : wc[15:8]}, 1'b0);
        if (dt >= 6'h10) begin
            for (int k = 0; k < int'(wc); k++) stream.push_back(seed + 8'(k));
            stream.push_back(8'hCC);
            stream.push_back(8'hCC);
            if (dt == DT_RAW10) begin
                for (int g = 0; g < int'(wc) / 5; g++)
                    exp_q.push_back(make_group(stream[5*g], stream[5*g+1], stream[5*g+2],
                                               stream[5*g+3], stream[5*g+4]));
            end
            while (stream.size() > 0) begin
                lo = stream.pop_front();
                hi = (stream.size() > 0) ? stream.pop_front() : 8'h00;
                maybe_gap(gaps);
                beat({hi, lo}, 1'b0);
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [5:0]  dt;
        logic [15:0] wc;
        logic [7:0]  seed;
        bit          gaps;
        int          exp_pix;
        int          exp_err;
        int          exp_fs;
        int          exp_fe;
        int          line_inc;
        bit          line_clr;
    } vec_t;

    vec_t vecs[10];

    int p0, e0, s0, f0;

    initial begin
        vecs[0] = '{6'h00,    16'd0,  8'h00, 1'b0, 0, 0, 1, 0, 0, 1'b1}; // FS
        vecs[1] = '{DT_RAW10, 16'd5,  8'h10, 1'b0, 1, 0, 0, 0, 1, 1'b0};
        vecs[2] = '{DT_RAW10, 16'd10, 8'h00, 1'b0, 2, 0, 0, 0, 1, 1'b0};
        vecs[3] = '{DT_RAW10, 16'd7,  8'h20, 1'b0, 1, 1, 0, 0, 0, 1'b0}; // truncated group
        vecs[4] = '{DT_RAW10, 16'd0,  8'h00, 1'b0, 0, 0, 0, 0, 0, 1'b0}; // empty long packet
        vecs[5] = '{6'h12,    16'd8,  8'h30, 1'b1, 0, 0, 0, 0, 0, 1'b0}; // other long type
        vecs[6] = '{6'h05,    16'd0,  8'h00, 1'b0, 0, 0, 0, 0, 0, 1'b0}; // generic short
        vecs[7] = '{DT_RAW10, 16'd15, 8'h80, 1'b1, 3, 0, 0, 0, 1, 1'b0};
        vecs[8] = '{DT_RAW10, 16'd6,  8'hF0, 1'b0, 1, 1, 0, 0, 0, 1'b0};
        vecs[9] = '{6'h01,    16'd0,  8'h00, 1'b0, 0, 0, 0, 1, 0, 1'b0}; // FE

        // ---- reset values ----
        repeat (3) @(negedge clk);
        check("rst_pixel_data", 64'(pixel_data), 64'd0);
        check("rst_pixel_vld", 64'(pixel_vld), 64'd0);
        check("rst_frame_start", 64'(frame_start), 64'd0);
        check("rst_frame_end", 64'(frame_end), 64'd0);
        check("rst_line_cnt", 64'(line_cnt), 64'd0);
        check("rst_pkt_err", 64'(pkt_err), 64'd0);
        check("rst_state", 64'(dbg_state), 64'd0);
        s_rst_n = 1'b1;
        idle();

        // ---- FS header with pulse timing ----
        beat(16'h0000, 1'b1);
        beat(16'h0000, 1'b0);
        idle();
        check("fs_pulse_t1", 64'(frame_start), 64'd1);
        check("fs_line_cnt", 64'(line_cnt), 64'd0);
        idle();
        check("fs_pulse_width", 64'(frame_start), 64'd0);
        check("fs_no_pix", 64'(pix_cnt), 64'd0);

        // ---- literal RAW10 wc=5 example ----
        beat(16'h052B, 1'b1);
        beat(16'h0000, 1'b0);
        beat(16'hB2A1, 1'b0);
        beat(16'hD4C3, 1'b0);
        exp_q.push_back(40'hA12C9C3B53);
        beat(16'h77E4, 1'b0);
        check("ex_no_early_vld", 64'(pixel_vld), 64'd0);
        beat(16'h0077, 1'b0);
        check("ex_vld_t1", 64'(pixel_vld), 64'd1);
        check("ex_data", 64'(pixel_data), 64'hA12C9C3B53);
        check("ex_line_t1", 64'(line_cnt), 64'd1);
        idle();
        check("ex_vld_pulse", 64'(pixel_vld), 64'd0);
        check("ex_state_idle", 64'(dbg_state), 64'd0);
        settle();
        check("ex_data_hold", 64'(pixel_data), 64'hA12C9C3B53);
        check("ex_pix_once", 64'(pix_cnt), 64'd1);
        exp_line = 1;

        // ---- table-driven packets ----
        for (int v = 0; v < 10; v++) begin
            p0 = pix_cnt; e0 = err_cnt; s0 = fs_cnt; f0 = fe_cnt;
            send_pkt(vecs[v].dt, vecs[v].wc, vecs[v].seed, vecs[v].gaps);
            settle();
            exp_line = vecs[v].line_clr ? 0 : exp_line + vecs[v].line_inc;
            check($sformatf("v%0d_pix", v), 64'(pix_cnt - p0), 64'(vecs[v].exp_pix));
            check($sformatf("v%0d_err", v), 64'(err_cnt - e0), 64'(vecs[v].exp_err));
            check($sformatf("v%0d_fs", v), 64'(fs_cnt - s0), 64'(vecs[v].exp_fs));
            check($sformatf("v%0d_fe", v), 64'(fe_cnt - f0), 64'(vecs[v].exp_fe));
            check($sformatf("v%0d_line", v), 64'(line_cnt), 64'(exp_line));
            check($sformatf("v%0d_state", v), 64'(dbg_state), 64'd0);
        end

        // ---- SOP on second payload beat of a wc=10 packet ----
        p0 = pix_cnt; e0 = err_cnt;
        beat(16'h0A2B, 1'b1);
        beat(16'hEC00, 1'b0);
        beat(16'h0100, 1'b0);
        send_pkt(DT_RAW10, 16'd5, 8'h40, 1'b0);
        settle();
        exp_line = exp_line + 1;
        check("abort_err", 64'(err_cnt - e0), 64'd1);
        check("abort_pix", 64'(pix_cnt - p0), 64'd1);
        check("abort_line", 64'(line_cnt), 64'(exp_line));
        check("abort_state", 64'(dbg_state), 64'd0);

        // ---- reset in the middle of a packet ----
        beat(16'h0A2B, 1'b1);
        beat(16'hEC00, 1'b0);
        beat(16'h0201, 1'b0);
        beat(16'h0403, 1'b0);
        @(negedge clk);
        csi_vld = 1'b0;
        csi_sop = 1'b0;
        s_rst_n = 1'b0;
        #1;
        check("mrst_state", 64'(dbg_state), 64'd0);
        check("mrst_line", 64'(line_cnt), 64'd0);
        check("mrst_pix_vld", 64'(pixel_vld), 64'd0);
        check("mrst_pix_data", 64'(pixel_data), 64'd0);
        @(negedge clk);
        s_rst_n = 1'b1;
        p0 = pix_cnt; e0 = err_cnt;
        send_pkt(DT_RAW10, 16'd5, 8'h60, 1'b0);
        settle();
        check("mrst_after_pix", 64'(pix_cnt - p0), 64'd1);
        check("mrst_after_err", 64'(err_cnt - e0), 64'd0);
        check("mrst_after_line", 64'(line_cnt), 64'd1);

        check("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/csi2_raw10_depacker.md
# csi2_raw10_depacker

Parses the CSI-2 packet stream from the D-PHY lane merger and unpacks RAW10 payload into 4-pixel groups. It sits directly upstream of the write-FIFO control stage, and its pixel_data/pixel_vld outputs drive that stage's pixel inputs. Frame-start and frame-end short packets produce pulses, and a per-frame line count is kept. Malformed or truncated packets are flagged and dropped without stalling.

## Interface
- DT_RAW10, 6'h2B: data type accepted as pixel payload.
- LINE_W, 12: width of line_cnt.
- wfifo_wr_clk  in  1  clock.
- s_rst_n  in  1  reset, asynchronous, active-low.
- csi_data  in  16  two bytes per beat; byte0 = [7:0] arrives first.
- csi_vld  in  1  beat qualifier; no backpressure is exerted.
- csi_sop  in  1  marks the first beat of a packet; meaningful only when csi_vld=1.
- pixel_data  out  40  {P0,P1,P2,P3}, 10 bits each; P0 occupies [39:30].
- pixel_vld  out  1  one-cycle strobe per complete 5-byte group.
- frame_start  out  1  one-cycle pulse on FS short packet (DI[5:0]=0x00).
- frame_end  out  1  one-cycle pulse on FE short packet (DI[5:0]=0x01).
- line_cnt  out  LINE_W  RAW10 lines completed since the last FS; saturates at all-ones.
- pkt_err  out  1  one-cycle pulse on a protocol error.

## Operation
- FSM states: IDLE, HDR, PAYLOAD, CRC.
- IDLE, on csi_vld&csi_sop: latch DI=byte0 and wc_lo=byte1, then go to HDR. A beat with csi_vld=1 but no sop is ignored.
- HDR, on csi_vld: wc={byte0,wc_lo}; byte1 (ECC) is ignored. Decode DI[5:0]:
  - 0x00: pulse frame_start, clear line_cnt, go to IDLE.
  - 0x01: pulse frame_end, go to IDLE.
  - Other value <0x10 (short packet): go to IDLE.
  - DT_RAW10 with wc≠0: go to PAYLOAD in keep mode, remaining=wc.
  - Other long type, or wc=0: go to PAYLOAD in discard mode. For wc=0, go straight to CRC.
- PAYLOAD, per csi_vld beat: consume min(2, remaining) bytes in order. In keep mode, each byte is pushed into a 5-byte gather register, grp_cnt 0..4.
  - On the 5th byte: B0..B3 are MSBs and B4 holds LSBs. P0={B0,B4[1:0]}, P1={B1,B4[3:2]}, P2={B2,B4[5:4]}, P3={B3,B4[7:6]}. pixel_vld is asserted and grp_cnt returns to 0.
  - When remaining hits 0, go to CRC with crc_left=2. If the final beat used only byte0, byte1 counts as the first CRC byte and crc_left=1.
  - At end of a keep packet: if grp_cnt≠0, pulse pkt_err and discard the partial group. Otherwise increment line_cnt (saturating).
- CRC: consume crc_left bytes (CRC is not checked), then go to IDLE. A beat that finishes the CRC with leftover bytes drops those bytes.
- csi_sop in HDR, PAYLOAD, or CRC: pulse pkt_err, discard the gather buffer (no pixel_vld, no line_cnt increment), and treat the beat as a new header (go to HDR).
- Arithmetic: remaining is 16 bits and decrements by 1 or 2 without underflow. grp_cnt is 3 bits.

## Timing
- Reset: all outputs 0; FSM=IDLE; grp_cnt=0.
- All outputs are registered.
- pixel_vld is asserted 1 cycle after the beat carrying the 5th byte. pixel_data holds until the next strobe.
- Consecutive pixel_vld pulses are at least 2 cycles apart (at most 2 bytes per beat).
- frame_start/frame_end assert 1 cycle after the HDR beat.
- line_cnt updates 1 cycle after the last payload beat. pkt_err asserts 1 cycle after the causing beat.
- Gaps in csi_vld freeze all state; no timeout.
- Reset mid-packet returns to IDLE immediately and any partial group is lost.

## Test plan
- FS header beats 0x0000(sop), 0x0000 → frame_start pulse at cycle+1, line_cnt=0, no pixel_vld.
- RAW10 packet with wc=5: beats 0x052B(sop), 0xXX00, 0xB2A1, 0xD4C3, 0x??E4 (byte1 = CRC0), CRC1 → exactly one pixel_vld, pixel_data=0xA12C9C3B53, line_cnt=1.
- wc=10 with bytes 0x00..0x09 → two pixel_vld pulses ≥2 cycles apart, line_cnt increments once, no pkt_err.
- wc=7 RAW10 → one pixel_vld, pkt_err pulse at end, line_cnt unchanged, FSM back in IDLE after CRC.
- csi_sop asserted on the 2nd payload beat of a wc=10 packet → pkt_err, no pixel_vld from the old packet, and the new header is parsed correctly.
- Long packet DT=0x12 with wc=8 interleaved with random csi_vld gaps → no pixel_vld, no pkt_err; a following FE packet produces a frame_end pulse.
